receptor_fifos: RTL and testbench
=================================

Name: receptor_fifos

Overview:
- Output-side FIFO bank that receives the arbiter's one-hot Push plus data and buffers each word in one of four destination FIFOs.
- Generates the per-lane Almost_full back-pressure that the arbiter uses to withhold Pops.
- A downstream reader drains each lane independently with its own pop.
- Sits between the arbiter and the four destination ports.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 3, pointer width per lane; lane depth = 2**ADDR_WIDTH (8).
- AF_THRESH, 6, Almost_full[i] asserts when lane i occupancy >= AF_THRESH; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Push  input  4  one-hot write strobe, bit i selects lane i.
- data_in  input  DATA_WIDTH  word written on Push.
- pop  input  4  per-lane read request from the downstream reader; any combination is legal.
- data_out  output  4*DATA_WIDTH  lane i word on bits [i*DATA_WIDTH +: DATA_WIDTH], registered.
- valid_out  output  4  bit i high for one cycle when data_out lane i holds a newly popped word.
- Almost_full  output  4  per-lane back-pressure to the arbiter.
- FIFO_empty  output  4  per-lane occupancy == 0.
- FIFO_full  output  4  per-lane occupancy == 2**ADDR_WIDTH.
- error  output  4  sticky per-lane overflow, underflow or illegal-push flag.

Behaviour:
- Reset: clk domain only. Asserting reset asynchronously clears all lanes:
  - pointers and counts = 0
  - data_out = 0, valid_out = 0
  - Almost_full = 0, FIFO_full = 0, error = 0
  - FIFO_empty = 4'b1111
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored words; first legal push after release is accepted on the next rising edge.
- Per lane: circular buffer with wr_ptr and rd_ptr of ADDR_WIDTH bits each, wrapping from 2**ADDR_WIDTH-1 to 0. Count is ADDR_WIDTH+1 bits.
- Write: on a rising edge with Push == one-hot bit i and lane i not full (or full with pop[i] the same cycle):
  - mem[wr_ptr] <= data_in, wr_ptr increments.
- Illegal push: Push with more than one bit set writes nothing; error is set on every asserted lane. Push == 0 is idle.
- Overflow: push to a full lane without a simultaneous pop is dropped; error[i] <= 1; contents unchanged.
- Read: pop[i] with count > 0 sets data_out lane i <= mem[rd_ptr] and valid_out[i] <= 1 on that edge (1-cycle latency); rd_ptr increments.
  - data_out holds its value until the next successful pop.
  - valid_out[i] = 0 on any cycle without a successful pop.
- Underflow: pop[i] on an empty lane is ignored; valid_out[i] stays 0; error[i] <= 1.
  - A simultaneous push to that empty lane is still accepted; no bypass, so the word is readable from the next cycle.
- Simultaneous push and pop on a non-empty lane: both performed, count unchanged.
- Count updates: +1 on push only, -1 on pop only, unchanged on both or neither.
- Status flags are registered, derived from the next-state count, so they are valid in the same cycle as the updated count:
  - FIFO_empty[i] = (count == 0)
  - FIFO_full[i] = (count == 2**ADDR_WIDTH)
  - Almost_full[i] = (count >= AF_THRESH)
- error bits are sticky; only reset clears them.
- Lanes are fully independent apart from the shared data_in.

Test Plan:
- Reset check: assert reset asynchronously between clock edges. Outputs clear immediately: FIFO_empty = 4'b1111, Almost_full = 0, FIFO_full = 0, error = 0, valid_out = 0, data_out = 0.
- Fill and overflow: Push = 4'b0100 with data 8'h10..8'h17 over 8 cycles.
  - Almost_full[2] rises after the 6th edge; FIFO_full[2] rises after the 8th.
  - A 9th push of 8'hAA gives error[2] = 1 and leaves occupancy at 8.
  - Other lanes remain empty with error = 0.
- Read latency and wrap: pop[2] for 8 cycles returns 8'h10..8'h17 in order, one cycle after each pop, with valid_out[2] = 1 each cycle.
  - FIFO_empty[2] = 1 after the last pop.
  - Refill 5 words and pop them; the wrapped pointers return correct data.
- Simultaneous push and pop on lane 0 holding 3 words: count stays 3, the oldest word appears on data_out lane 0, and Almost_full[0] is unchanged.
- Underflow: pop[1] on empty lane 1 gives valid_out[1] = 0 and error[1] = 1. The same-cycle Push = 4'b0010 with 8'h5A is stored and is popped next cycle as 8'h5A.
- Illegal push: Push = 4'b0011 writes nothing to lanes 0 or 1; error[0] = 1 and error[1] = 1; FIFO_empty remains unchanged.

Source files
------------

// File: rtl/receptor_fifos.sv
// receptor_fifos: four independent destination FIFOs fed by a one-hot push, with
// registered status flags, registered read data and sticky per-lane error flags.
module receptor_fifos #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              Push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [3:0]              pop,
    output logic [4*DATA_WIDTH-1:0] data_out,
    output logic [3:0]              valid_out,
    output logic [3:0]              Almost_full,
    output logic [3:0]              FIFO_empty,
    output logic [3:0]              FIFO_full,
    output logic [3:0]              error
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AF = CW'(AF_THRESH);
    logic multi, one_hot;
    assign multi   = (Push & (Push - 4'd1)) != 4'd0;
    assign one_hot = Push != 4'd0 && !multi;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
        logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0]         cnt, cnt_nx;
        logic                  do_push, do_pop, err_set;
        logic [DATA_WIDTH-1:0] dq;
        logic                  v, af, emp, fl, er;
        // A full lane still accepts a push when the same edge pops it.
        always_comb begin
            do_pop  = pop[i] && cnt != '0;
            do_push = one_hot && Push[i] && (cnt != DEPTH || pop[i]);
            err_set = (multi && Push[i]) || (one_hot && Push[i] && cnt == DEPTH && !pop[i]) || (pop[i] && cnt == '0);
            cnt_nx  = cnt + CW'(do_push) - CW'(do_pop);
        end
        always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= data_in;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                dq     <= '0;
                v      <= 1'b0;
                af     <= 1'b0;
                emp    <= 1'b1;
                fl     <= 1'b0;
                er     <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (do_pop) begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                    dq     <= mem[rd_ptr];
                end
                v   <= do_pop;
                cnt <= cnt_nx;
                emp <= cnt_nx == '0;
                fl  <= cnt_nx == DEPTH;
                af  <= cnt_nx >= AF;
                er  <= er | err_set;
            end
        end
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = dq;
        assign valid_out[i]   = v;
        assign Almost_full[i] = af;
        assign FIFO_empty[i]  = emp;
        assign FIFO_full[i]   = fl;
        assign error[i]       = er;
    end
endmodule

// File: tb/tb_receptor_fifos.sv
// tb_receptor_fifos: directed plus randomized checks of receptor_fifos against a
// queue-based model of the four lanes.
module tb_receptor_fifos;
    logic        clk = 1'b0, reset = 1'b0;
    logic [3:0]  Push = '0, pop = '0;
    logic [7:0]  data_in = '0;
    logic [31:0] data_out;
    logic [3:0]  valid_out, Almost_full, FIFO_empty, FIFO_full, error;
    int total = 0, bad = 0;

    logic [7:0] q [4][$];
    logic [7:0] m_dout [4];
    logic [3:0] m_valid, m_err;

    always #5 clk = ~clk;

    receptor_fifos dut (
        .clk(clk), .reset(reset), .Push(Push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .Almost_full(Almost_full),
        .FIFO_empty(FIFO_empty), .FIFO_full(FIFO_full), .error(error)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            m_dout[i] = '0;
        end
        m_valid = '0;
        m_err   = '0;
    endtask

    // Pops see the contents before this edge; a pop frees room for a same-edge push.
    task automatic model_step();
        bit oh;
        int sz;
        oh = $countones(Push) == 1;
        for (int i = 0; i < 4; i++) begin
            sz = q[i].size();
            m_valid[i] = 1'b0;
            if (pop[i]) begin
                if (sz > 0) begin
                    m_dout[i]  = q[i].pop_front();
                    m_valid[i] = 1'b1;
                end else m_err[i] = 1'b1;
            end
            if (Push[i]) begin
                if (!oh) m_err[i] = 1'b1;
                else if (sz < 8 || pop[i]) q[i].push_back(data_in);
                else m_err[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e_emp, e_full, e_af;
        for (int i = 0; i < 4; i++) begin
            e_emp[i]  = q[i].size() == 0;
            e_full[i] = q[i].size() == 8;
            e_af[i]   = q[i].size() >= 6;
        end
        cmp("data_out", data_out, {m_dout[3], m_dout[2], m_dout[1], m_dout[0]});
        cmp("valid_out", 32'(valid_out), 32'(m_valid));
        cmp("FIFO_empty", 32'(FIFO_empty), 32'(e_emp));
        cmp("FIFO_full", 32'(FIFO_full), 32'(e_full));
        cmp("Almost_full", 32'(Almost_full), 32'(e_af));
        cmp("error", 32'(error), 32'(m_err));
    endtask

    task automatic cyc(input logic [3:0] p, input logic [7:0] d, input logic [3:0] po);
        Push = p;
        data_in = d;
        pop = po;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        Push = '0;
        pop = '0;
        model_clear();
        #1;
        check_all();
        cmp("rst_empty", 32'(FIFO_empty), 32'hF);
        cmp("rst_err", 32'(error), 32'h0);
        cmp("rst_dout", data_out, 32'h0);
        @(posedge clk);
        #1 check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] pp, po;
        int r;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0100, 8'(8'h10 + k), 4'b0000);
            if (k == 4) cmp("af_before", 32'(Almost_full[2]), 32'h0);
            if (k == 5) cmp("af_at6", 32'(Almost_full[2]), 32'h1);
            if (k == 6) cmp("full_before", 32'(FIFO_full[2]), 32'h0);
            if (k == 7) cmp("full_at8", 32'(FIFO_full[2]), 32'h1);
        end
        cyc(4'b0100, 8'hAA, 4'b0000);
        cmp("ovf_err", 32'(error), 32'h4);
        cmp("ovf_full", 32'(FIFO_full), 32'h4);
        cmp("ovf_empty", 32'(FIFO_empty), 32'hB);
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0000, 8'h00, 4'b0100);
            cmp("pop_data", 32'(data_out[23:16]), 32'(8'h10 + k));
            cmp("pop_valid", 32'(valid_out), 32'h4);
        end
        cmp("drained", 32'(FIFO_empty[2]), 32'h1);
        for (int k = 0; k < 5; k++) cyc(4'b0100, 8'(8'h20 + k), 4'b0000);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0000, 8'h00, 4'b0100);
            cmp("wrap_data", 32'(data_out[23:16]), 32'(8'h20 + k));
        end
        for (int k = 0; k < 3; k++) cyc(4'b0001, 8'(8'h30 + k), 4'b0000);
        cyc(4'b0001, 8'h33, 4'b0001);
        cmp("pp_data", 32'(data_out[7:0]), 32'h30);
        cmp("pp_af", 32'(Almost_full[0]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0000, 8'h00, 4'b0001);
            cmp("pp_rest", 32'(data_out[7:0]), 32'(8'h31 + k));
        end
        cmp("pp_empty", 32'(FIFO_empty[0]), 32'h1);
        cyc(4'b0010, 8'h5A, 4'b0010);
        cmp("udf_valid", 32'(valid_out[1]), 32'h0);
        cmp("udf_err", 32'(error[1]), 32'h1);
        cyc(4'b0000, 8'h00, 4'b0010);
        cmp("udf_data", 32'(data_out[15:8]), 32'h5A);
        cmp("udf_valid2", 32'(valid_out[1]), 32'h1);
        cyc(4'b0011, 8'h77, 4'b0000);
        cmp("ill_empty", 32'(FIFO_empty), 32'hF);
        cmp("ill_err", 32'(error), 32'h7);
        cyc(4'b1000, 8'hB1, 4'b0000);
        cyc(4'b1000, 8'hB2, 4'b0000);
        do_reset();
        cyc(4'b1000, 8'hC3, 4'b0000);
        cyc(4'b0000, 8'h00, 4'b1000);
        cmp("post_rst", 32'(data_out[31:24]), 32'hC3);
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) do_reset();
            r = $urandom_range(0, 9);
            pp = r < 6 ? 4'(1 << $urandom_range(0, 3)) : r < 8 ? 4'h0 : 4'($urandom_range(0, 15));
            po = ((n / 125) % 2) != 0 ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
            cyc(pp, 8'($urandom), po);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
